// File: rtl/gsm_pkg.sv
// Shared codes for the gsm event sequencer: command flags, gsm state codes and
// the handshake FSM state type.
package gsm_pkg;

  localparam logic [3:0] FLAG_NONE        = 4'b0000;
  localparam logic [3:0] FLAG_SCORE_INC   = 4'b0001;
  localparam logic [3:0] FLAG_LIFE_DEC    = 4'b0010;
  localparam logic [3:0] FLAG_PAUSE       = 4'b0100;
  localparam logic [3:0] FLAG_RESUME      = 4'b0101;
  localparam logic [3:0] FLAG_TO_READY    = 4'b1000;
  localparam logic [3:0] FLAG_TO_PLAYING  = 4'b1010;
  localparam logic [3:0] FLAG_STAGE_CLEAR = 4'b1100;
  localparam logic [3:0] FLAG_GAME_OVER   = 4'b1101;
  localparam logic [3:0] FLAG_GAME_CLEAR  = 4'b1110;
  localparam logic [3:0] FLAG_RESET       = 4'b1111;

  localparam logic [2:0] GSM_READY       = 3'd0;
  localparam logic [2:0] GSM_PLAYING     = 3'd1;
  localparam logic [2:0] GSM_PAUSED      = 3'd2;
  localparam logic [2:0] GSM_STAGE_CLEAR = 3'd3;
  localparam logic [2:0] GSM_GAME_OVER   = 3'd4;
  localparam logic [2:0] GSM_GAME_CLEAR  = 3'd5;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_RELEASE
  } seq_state_t;

endpackage

// File: rtl/gsm_event_sequencer_if.sv
// Command handshake and status bus between the event sequencer (master) and
// the game state manager (slave).
interface gsm_event_sequencer_if;
  logic [3:0] flag;
  logic       trig;
  logic       done;
  logic [6:0] timer;
  logic [2:0] state;
  logic [1:0] stage;
  logic [1:0] lives;
  logic [9:0] score;

  modport master (output flag, trig, input done, timer, state, stage, lives, score);
  modport slave  (input flag, trig, output done, timer, state, stage, lives, score);
endinterface

// File: rtl/sat_pend_counter.sv
// Saturating pending-event counter; a simultaneous inc and dec cancel out.
module sat_pend_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !dec && cnt != CNT_MAX)
      cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign nz = |cnt;

endmodule

// File: rtl/gsm_event_sequencer.sv
// Buffers gameplay events and issues one gsm command at a time over a
// trig/done handshake.
//   state        | meaning
//   SEQ_IDLE     | pick the highest-priority pending command, latch flag
//   SEQ_ISSUE    | trig high, wait for done or timeout
//   SEQ_RELEASE  | trig low, wait for done to drop
module gsm_event_sequencer
  import gsm_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int SCORE_TARGET = 10,
  parameter int NUM_STAGES   = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk_1mhz,
  input  logic                  rst,
  input  logic                  hit_pulse,
  input  logic                  miss_pulse,
  input  logic                  start_pulse,
  input  logic                  pause_pulse,
  gsm_event_sequencer_if.master gsm,
  output logic                  busy,
  output logic                  err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  seq_state_t       seq_state;
  logic [3:0]       flag_q;
  logic             trig_q;
  logic             start_pend, pause_pend;
  logic [TMO_W-1:0] tmo_cnt;

  logic             playing, clr_pend, score_met, last_stage;
  logic [11:0]      target;
  logic             hit_nz, miss_nz;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic             unused_cnt_bits;

  logic             cmd_valid, take_start, take_pause, take_hit, take_miss;
  logic [3:0]       cmd_flag;

  assign playing    = (gsm.state == GSM_PLAYING);
  // Events only count toward play; anything caught outside PLAYING is dropped.
  assign clr_pend   = ~playing;
  assign target     = 12'(SCORE_TARGET) * (12'(gsm.stage) + 12'd1);
  assign score_met  = ({2'b00, gsm.score} >= target);
  assign last_stage = (gsm.stage == 2'(NUM_STAGES - 1));
  assign unused_cnt_bits = ^{hit_cnt, miss_cnt};

  sat_pend_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk_1mhz), .rst(rst), .inc(hit_pulse), .dec(take_hit), .clr(clr_pend),
    .cnt(hit_cnt), .nz(hit_nz)
  );

  sat_pend_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk_1mhz), .rst(rst), .inc(miss_pulse), .dec(take_miss), .clr(clr_pend),
    .cnt(miss_cnt), .nz(miss_nz)
  );

  always_comb begin
    cmd_valid  = 1'b0;
    cmd_flag   = FLAG_NONE;
    take_start = 1'b0;
    take_pause = 1'b0;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    if (seq_state == SEQ_IDLE) begin
      if (start_pend) begin
        take_start = 1'b1;
        case (gsm.state)
          GSM_READY, GSM_STAGE_CLEAR: begin cmd_valid = 1'b1; cmd_flag = FLAG_TO_PLAYING; end
          GSM_GAME_OVER, GSM_GAME_CLEAR: begin cmd_valid = 1'b1; cmd_flag = FLAG_RESET; end
          default: ;
        endcase
      end else if (playing && gsm.lives == 2'd0) begin
        cmd_valid = 1'b1;
        cmd_flag  = FLAG_GAME_OVER;
      end else if (playing && gsm.timer == 7'd0) begin
        cmd_valid = 1'b1;
        if (!score_met)     cmd_flag = FLAG_GAME_OVER;
        else if (last_stage) cmd_flag = FLAG_GAME_CLEAR;
        else                cmd_flag = FLAG_STAGE_CLEAR;
      end else if (playing && miss_nz) begin
        cmd_valid = 1'b1;
        cmd_flag  = FLAG_LIFE_DEC;
        take_miss = 1'b1;
      end else if (playing && hit_nz) begin
        cmd_valid = 1'b1;
        cmd_flag  = FLAG_SCORE_INC;
        take_hit  = 1'b1;
      end else if (pause_pend) begin
        take_pause = 1'b1;
        if (playing) begin
          cmd_valid = 1'b1; cmd_flag = FLAG_PAUSE;
        end else if (gsm.state == GSM_PAUSED) begin
          cmd_valid = 1'b1; cmd_flag = FLAG_RESUME;
        end
      end
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      seq_state  <= SEQ_IDLE;
      flag_q     <= FLAG_NONE;
      trig_q     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      start_pend <= 1'b0;
      pause_pend <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      start_pend <= (start_pend & ~take_start) | start_pulse;
      pause_pend <= (pause_pend & ~take_pause) | pause_pulse;
      case (seq_state)
        SEQ_IDLE: if (cmd_valid) begin
          flag_q    <= cmd_flag;
          trig_q    <= 1'b1;
          busy      <= 1'b1;
          tmo_cnt   <= TMO_W'(TIMEOUT - 1);
          seq_state <= SEQ_ISSUE;
        end
        SEQ_ISSUE: begin
          if (gsm.done) begin
            trig_q    <= 1'b0;
            seq_state <= SEQ_RELEASE;
          end else if (tmo_cnt == '0) begin
            err       <= 1'b1;
            trig_q    <= 1'b0;
            seq_state <= SEQ_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        SEQ_RELEASE: if (!gsm.done) begin
          busy      <= 1'b0;
          seq_state <= SEQ_IDLE;
        end
        default: seq_state <= SEQ_IDLE;
      endcase
    end
  end

  assign gsm.flag = flag_q;
  assign gsm.trig = trig_q;

endmodule

// File: tb/tb_gsm_event_sequencer.sv
// Directed bench for gsm_event_sequencer: a vector table for command selection
// plus hand-written handshake, buffering, saturation, timeout and reset cases.
module tb_gsm_event_sequencer;

  localparam logic [2:0] S_READY = 3'd0, S_PLAYING = 3'd1, S_PAUSED = 3'd2,
                         S_STAGE_CLEAR = 3'd3, S_GAME_OVER = 3'd4, S_GAME_CLEAR = 3'd5;

  logic clk_1mhz = 1'b0;
  logic rst;
  logic hit_pulse, miss_pulse, start_pulse, pause_pulse;
  logic busy, err;

  gsm_event_sequencer_if gsm_if();

  gsm_event_sequencer #(.CNT_W(4), .SCORE_TARGET(10), .NUM_STAGES(3), .TIMEOUT(255)) dut (
    .clk_1mhz(clk_1mhz), .rst(rst),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .gsm(gsm_if), .busy(busy), .err(err)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  int checks = 0;
  int errors = 0;
  logic [3:0] log_q[$];
  bit auto_ack = 1'b1;
  int ack_delay = 2;

  // gsm stand-in: logs each new command and raises done ack_delay cycles later
  initial begin
    int cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    gsm_if.done = 1'b0;
    forever begin
      @(negedge clk_1mhz);
      if (gsm_if.trig && !prev) begin
        log_q.push_back(gsm_if.flag);
        cnt = 0;
      end
      if (gsm_if.trig) begin
        if (auto_ack) begin
          if (cnt >= ack_delay) gsm_if.done = 1'b1;
          else cnt++;
        end
      end else begin
        gsm_if.done = 1'b0;
      end
      prev = gsm_if.trig;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1mhz);
    #1;
  endtask

  task automatic pulse(input int kind);
    case (kind)
      1: hit_pulse = 1'b1;
      2: miss_pulse = 1'b1;
      3: start_pulse = 1'b1;
      4: pause_pulse = 1'b1;
      default: ;
    endcase
    tick(1);
    hit_pulse = 1'b0; miss_pulse = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
  endtask

  task automatic set_neutral();
    gsm_if.state = S_READY; gsm_if.stage = 2'd0; gsm_if.lives = 2'd3;
    gsm_if.timer = 7'd50;   gsm_if.score = 10'd0;
  endtask

  task automatic wait_trig(input logic lvl, input int max, input string name);
    int n;
    n = 0;
    while (gsm_if.trig !== lvl && n < max) begin
      @(negedge clk_1mhz);
      n++;
    end
    check({name, "_wait_trig"}, 32'(gsm_if.trig), 32'(lvl));
  endtask

  task automatic drain(input int max, input string name);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 10 && n < max) begin
      @(negedge clk_1mhz);
      n++;
      if (busy || gsm_if.trig) quiet = 0;
      else quiet++;
    end
    check({name, "_drain"}, 32'(quiet >= 10), 32'd1);
  endtask

  typedef struct {
    logic [2:0] st;
    logic [1:0] stg;
    logic [1:0] lv;
    logic [6:0] tmr;
    logic [9:0] sc;
    int         ev;      // 0 none, 1 hit, 2 miss, 3 start, 4 pause
    int         exp_n;
    logic [3:0] exp_flag;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int n, cnt_inc;
    vecs[0]  = '{S_PLAYING,     2'd0, 2'd3, 7'd50, 10'd0,  1, 1, 4'b0001};
    vecs[1]  = '{S_PLAYING,     2'd0, 2'd3, 7'd50, 10'd0,  2, 1, 4'b0010};
    vecs[2]  = '{S_READY,       2'd0, 2'd3, 7'd50, 10'd0,  3, 1, 4'b1010};
    vecs[3]  = '{S_STAGE_CLEAR, 2'd1, 2'd3, 7'd50, 10'd12, 3, 1, 4'b1010};
    vecs[4]  = '{S_GAME_OVER,   2'd0, 2'd0, 7'd50, 10'd0,  3, 1, 4'b1111};
    vecs[5]  = '{S_GAME_CLEAR,  2'd2, 2'd3, 7'd0,  10'd30, 3, 1, 4'b1111};
    vecs[6]  = '{S_PLAYING,     2'd0, 2'd3, 7'd50, 10'd0,  3, 0, 4'b0000};
    vecs[7]  = '{S_PLAYING,     2'd0, 2'd3, 7'd50, 10'd0,  4, 1, 4'b0100};
    vecs[8]  = '{S_PAUSED,      2'd0, 2'd3, 7'd50, 10'd0,  4, 1, 4'b0101};
    vecs[9]  = '{S_READY,       2'd0, 2'd3, 7'd50, 10'd0,  4, 0, 4'b0000};
    vecs[10] = '{S_PLAYING,     2'd0, 2'd0, 7'd50, 10'd0,  0, 1, 4'b1101};
    vecs[11] = '{S_PLAYING,     2'd0, 2'd3, 7'd0,  10'd10, 0, 1, 4'b1100};
    vecs[12] = '{S_PLAYING,     2'd0, 2'd3, 7'd0,  10'd9,  0, 1, 4'b1101};
    vecs[13] = '{S_PLAYING,     2'd2, 2'd3, 7'd0,  10'd30, 0, 1, 4'b1110};
    vecs[14] = '{S_PLAYING,     2'd2, 2'd3, 7'd0,  10'd29, 0, 1, 4'b1101};
    vecs[15] = '{S_PLAYING,     2'd1, 2'd3, 7'd0,  10'd20, 0, 1, 4'b1100};
    vecs[16] = '{S_READY,       2'd0, 2'd3, 7'd50, 10'd0,  1, 0, 4'b0000};
    vecs[17] = '{S_PAUSED,      2'd0, 2'd3, 7'd50, 10'd0,  1, 0, 4'b0000};

    rst = 1'b1;
    hit_pulse = 1'b0; miss_pulse = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
    set_neutral();
    tick(2);
    check("rst_flag", 32'(gsm_if.flag), 32'd0);
    check("rst_trig", 32'(gsm_if.trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    @(negedge clk_1mhz);
    rst = 1'b0;
    tick(3);
    check("post_rst_trig", 32'(gsm_if.trig), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // command selection table
    auto_ack = 1'b1; ack_delay = 2;
    for (int i = 0; i < 18; i++) begin
      set_neutral();
      tick(3);
      log_q.delete();
      gsm_if.state = vecs[i].st; gsm_if.stage = vecs[i].stg; gsm_if.lives = vecs[i].lv;
      gsm_if.timer = vecs[i].tmr; gsm_if.score = vecs[i].sc;
      pulse(vecs[i].ev);
      n = 0;
      while (log_q.size() == 0 && n < 20) begin
        @(negedge clk_1mhz);
        n++;
      end
      set_neutral();
      tick(12);
      check($sformatf("vec%0d_count", i), 32'(log_q.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && log_q.size() > 0)
        check($sformatf("vec%0d_flag", i), 32'(log_q[0]), 32'(vecs[i].exp_flag));
    end

    // handshake timing for a single hit
    set_neutral();
    gsm_if.state = S_PLAYING;
    tick(2);
    log_q.delete();
    pulse(1);
    @(negedge clk_1mhz);
    check("hs_trig_before", 32'(gsm_if.trig), 32'd0);
    @(negedge clk_1mhz);
    check("hs_trig_rise", 32'(gsm_if.trig), 32'd1);
    check("hs_flag", 32'(gsm_if.flag), 32'b0001);
    check("hs_busy_rise", 32'(busy), 32'd1);
    wait_trig(1'b0, 20, "hs_release");
    check("hs_busy_in_release", 32'(busy), 32'd1);
    @(negedge clk_1mhz);
    check("hs_busy_fall", 32'(busy), 32'd0);
    tick(10);
    check("hs_single_cmd", 32'(log_q.size()), 32'd1);

    // buffering: 5 hits + 1 miss during an outstanding command
    ack_delay = 12;
    log_q.delete();
    pulse(1);
    wait_trig(1'b1, 20, "buf");
    @(posedge clk_1mhz); #1;
    hit_pulse = 1'b1; miss_pulse = 1'b1;
    tick(1);
    miss_pulse = 1'b0;
    tick(4);
    hit_pulse = 1'b0;
    drain(400, "buf");
    check("buf_count", 32'(log_q.size()), 32'd7);
    if (log_q.size() == 7) begin
      check("buf_miss_first", 32'(log_q[1]), 32'b0010);
      for (int i = 2; i < 7; i++)
        check($sformatf("buf_hit%0d", i - 2), 32'(log_q[i]), 32'b0001);
    end

    // saturation: 20 hits while busy keep only 15
    ack_delay = 25;
    log_q.delete();
    pulse(1);
    wait_trig(1'b1, 20, "sat");
    @(posedge clk_1mhz); #1;
    hit_pulse = 1'b1;
    tick(20);
    hit_pulse = 1'b0;
    drain(1500, "sat");
    cnt_inc = 0;
    foreach (log_q[k]) if (log_q[k] == 4'b0001) cnt_inc++;
    check("sat_count", 32'(log_q.size()), 32'd16);
    check("sat_score_cmds", 32'(cnt_inc), 32'd16);

    // timeout: done never returns
    ack_delay = 2;
    auto_ack = 1'b0;
    log_q.delete();
    check("tmo_err_before", 32'(err), 32'd0);
    pulse(1);
    wait_trig(1'b1, 20, "tmo");
    n = 0;
    while (gsm_if.trig && n < 400) begin
      n++;
      @(negedge clk_1mhz);
    end
    check("tmo_trig_cycles", 32'(n), 32'd255);
    check("tmo_err_set", 32'(err), 32'd1);
    auto_ack = 1'b1;
    pulse(1);
    drain(100, "tmo_next");
    check("tmo_err_sticky", 32'(err), 32'd1);
    check("tmo_next_count", 32'(log_q.size()), 32'd2);

    // reset in the middle of ISSUE drops trig and all pending hits
    auto_ack = 1'b0;
    pulse(1);
    wait_trig(1'b1, 20, "rstmid");
    pulse(1); pulse(1); pulse(1);
    @(negedge clk_1mhz);
    rst = 1'b1;
    #1;
    check("rstmid_trig", 32'(gsm_if.trig), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk_1mhz);
    rst = 1'b0;
    auto_ack = 1'b1;
    log_q.delete();
    tick(20);
    check("rstmid_pending_lost", 32'(log_q.size()), 32'd0);
    pulse(1);
    drain(100, "rstmid_after");
    check("rstmid_after_count", 32'(log_q.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
